// File: rtl/speed_pkg.sv
// Shared constants for the speed tick generator/decoder pair: speed codes,
// 50 MHz default tick intervals and the decoder state encoding.
package speed_pkg;

  localparam logic [1:0] SPD_NONE    = 2'd0;
  localparam logic [1:0] SPD_EIGHTH  = 2'd1;
  localparam logic [1:0] SPD_QUARTER = 2'd2;
  localparam logic [1:0] SPD_HALF    = 2'd3;

  localparam int unsigned EIGHTH_CYC_50M  = 6250001;
  localparam int unsigned QUARTER_CYC_50M = 12500001;
  localparam int unsigned HALF_CYC_50M    = 25000001;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

endpackage

// File: rtl/speed_window_classify.sv
// Combinational classifier: matches a measured interval against the eighth,
// quarter and half windows (nominal +/- TOL), eighth taking priority.
module speed_window_classify
  import speed_pkg::*;
#(
  parameter int unsigned W           = 27,
  parameter int unsigned EIGHTH_CYC  = EIGHTH_CYC_50M,
  parameter int unsigned QUARTER_CYC = QUARTER_CYC_50M,
  parameter int unsigned HALF_CYC    = HALF_CYC_50M,
  parameter int unsigned TOL         = 1024
) (
  input  logic [W-1:0] p_i,
  output logic [1:0]   cls_o,
  output logic         match_o
);

  localparam logic [95:0] NOMINALS = {32'(HALF_CYC), 32'(QUARTER_CYC), 32'(EIGHTH_CYC)};

  logic [31:0] p_ext;
  logic [2:0]  hit;

  assign p_ext = 32'(p_i);

  for (genvar gi = 0; gi < 3; gi++) begin : g_win
    localparam logic [31:0] LO = NOMINALS[gi*32 +: 32] - 32'(TOL);
    localparam logic [31:0] HI = NOMINALS[gi*32 +: 32] + 32'(TOL);
    assign hit[gi] = (p_ext >= LO) && (p_ext <= HI);
  end

  always_comb begin
    cls_o = SPD_NONE;
    if (hit[0])      cls_o = SPD_EIGHTH;
    else if (hit[1]) cls_o = SPD_QUARTER;
    else if (hit[2]) cls_o = SPD_HALF;
  end

  assign match_o = |hit;

endmodule

// File: rtl/speed_tick_decoder.sv
// Measures the spacing of speed-tick rising edges and reports a locked speed code.
// Build option: SPEED_TICK_DECODER_LOCK2_EN requires two matching intervals to lock.
module speed_tick_decoder
  import speed_pkg::*;
#(
  parameter int unsigned W           = 27,
  parameter int unsigned EIGHTH_CYC  = EIGHTH_CYC_50M,
  parameter int unsigned QUARTER_CYC = QUARTER_CYC_50M,
  parameter int unsigned HALF_CYC    = HALF_CYC_50M,
  parameter int unsigned TOL         = 1024,
  parameter int unsigned TIMEOUT_CYC = 33554431
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic         tick,
  output logic [1:0]   speed_code,
  output logic         valid,
  output logic [W-1:0] period,
  output logic         timeout,
  output logic         bad_interval
);

  localparam logic [W-1:0] TO = W'(TIMEOUT_CYC);

  state_e       state_q, state_d;
  logic         tick_q;
  logic [W-1:0] count_q, count_d;
  logic [1:0]   code_q, code_d;
  logic         valid_q, valid_d;
  logic [W-1:0] period_q, period_d;
  logic         timeout_q, timeout_d;
  logic         bad_q, bad_d;
`ifdef SPEED_TICK_DECODER_LOCK2_EN
  logic [1:0]   cand_q, cand_d;
`endif

  logic         tick_rise;
  logic [W-1:0] p_w;
  logic [1:0]   cls_w;
  logic         match_w;

  assign tick_rise = tick & ~tick_q;
  assign p_w       = (&count_q) ? count_q : count_q + 1'b1;

  speed_window_classify #(
    .W          (W),
    .EIGHTH_CYC (EIGHTH_CYC),
    .QUARTER_CYC(QUARTER_CYC),
    .HALF_CYC   (HALF_CYC),
    .TOL        (TOL)
  ) u_classify (
    .p_i    (p_w),
    .cls_o  (cls_w),
    .match_o(match_w)
  );

  // tick_q resets high so a tick already high at reset release is not an edge.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      tick_q    <= 1'b1;
      state_q   <= ST_IDLE;
      count_q   <= '0;
      code_q    <= SPD_NONE;
      valid_q   <= 1'b0;
      period_q  <= '0;
      timeout_q <= 1'b0;
      bad_q     <= 1'b0;
`ifdef SPEED_TICK_DECODER_LOCK2_EN
      cand_q    <= SPD_NONE;
`endif
    end else begin
      tick_q    <= tick;
      state_q   <= state_d;
      count_q   <= count_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      period_q  <= period_d;
      timeout_q <= timeout_d;
      bad_q     <= bad_d;
`ifdef SPEED_TICK_DECODER_LOCK2_EN
      cand_q    <= cand_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
`ifdef SPEED_TICK_DECODER_LOCK2_EN
    cand_d  = cand_q;
`endif
    if (state_q == ST_IDLE) begin
      count_d = '0;
      if (tick_rise) state_d = ST_ARMED;
    end else if (tick_rise) begin
      // An edge always wins over a coincident timeout.
      count_d = '0;
      if (!match_w) begin
        state_d = ST_ARMED;
`ifdef SPEED_TICK_DECODER_LOCK2_EN
        cand_d  = SPD_NONE;
`endif
      end else begin
`ifdef SPEED_TICK_DECODER_LOCK2_EN
        if (cls_w == cand_q) begin
          state_d = ST_LOCKED;
        end else begin
          state_d = ST_ARMED;
          cand_d  = cls_w;
        end
`else
        state_d = ST_LOCKED;
`endif
      end
    end else if (count_q == TO) begin
      state_d = ST_IDLE;
      count_d = '0;
`ifdef SPEED_TICK_DECODER_LOCK2_EN
      cand_d  = SPD_NONE;
`endif
    end else begin
      count_d = count_q + 1'b1;
    end
  end

  always_comb begin
    code_d    = code_q;
    valid_d   = valid_q;
    period_d  = period_q;
    timeout_d = 1'b0;
    bad_d     = 1'b0;
    if (state_q != ST_IDLE) begin
      if (tick_rise) begin
        period_d = p_w;
        if (!match_w) begin
          bad_d   = 1'b1;
          code_d  = SPD_NONE;
          valid_d = 1'b0;
        end else if (state_d == ST_LOCKED) begin
          code_d  = cls_w;
          valid_d = 1'b1;
        end else begin
          code_d  = SPD_NONE;
          valid_d = 1'b0;
        end
      end else if (count_q == TO) begin
        timeout_d = 1'b1;
        code_d    = SPD_NONE;
        valid_d   = 1'b0;
      end
    end
  end

  assign speed_code   = code_q;
  assign valid        = valid_q;
  assign period       = period_q;
  assign timeout      = timeout_q;
  assign bad_interval = bad_q;

endmodule

// File: tb/tb_speed_tick_decoder.sv
// Scoreboard bench for speed_tick_decoder at small test parameters; follows
// SPEED_TICK_DECODER_LOCK2_EN when it is defined for the build.
module tb_speed_tick_decoder;

  localparam int W   = 8;
  localparam int NE  = 10;
  localparam int NQ  = 20;
  localparam int NH  = 40;
  localparam int TOL = 2;
  localparam int TO  = 64;

  logic         Clock = 1'b0;
  logic         Resetn;
  logic         tick;
  logic [1:0]   speed_code;
  logic         valid;
  logic [W-1:0] period;
  logic         timeout;
  logic         bad_interval;

  typedef struct {
    int period;
    int code;
    int valid;
    int bad;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  // Reference model of the decoder's observable state.
  int m_state = 0;  // 0 idle, 1 armed, 2 locked
  int m_code  = 0;
  int m_valid = 0;
  int m_period = 0;
  int m_cand  = 0;

  speed_tick_decoder #(
    .W          (W),
    .EIGHTH_CYC (NE),
    .QUARTER_CYC(NQ),
    .HALF_CYC   (NH),
    .TOL        (TOL),
    .TIMEOUT_CYC(TO)
  ) dut (
    .Clock       (Clock),
    .Resetn      (Resetn),
    .tick        (tick),
    .speed_code  (speed_code),
    .valid       (valid),
    .period      (period),
    .timeout     (timeout),
    .bad_interval(bad_interval)
  );

  always #5 Clock = ~Clock;

  task automatic check_val(input string tag, input int obs, input int exp_v);
    n_checks++;
    if (obs != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  function automatic bit in_win(input int p, input int n);
    return (p >= n - TOL) && (p <= n + TOL);
  endfunction

  function automatic void model_reset();
    m_state = 0; m_code = 0; m_valid = 0; m_period = 0; m_cand = 0;
  endfunction

  // Advance the model for a rising edge `gap` cycles after the previous one.
  function automatic exp_t model_edge(input int gap);
    exp_t e;
    int   cls;
    e.bad = 0;
    if (m_state == 0) begin
      m_state = 1;
    end else begin
      m_period = gap;
      cls = in_win(gap, NE) ? 1 : in_win(gap, NQ) ? 2 : in_win(gap, NH) ? 3 : 0;
      if (cls == 0) begin
        e.bad = 1; m_state = 1; m_code = 0; m_valid = 0; m_cand = 0;
      end else begin
`ifdef SPEED_TICK_DECODER_LOCK2_EN
        if (cls == m_cand) begin
          m_state = 2; m_code = cls; m_valid = 1;
        end else begin
          m_state = 1; m_cand = cls; m_code = 0; m_valid = 0;
        end
`else
        m_state = 2; m_code = cls; m_valid = 1;
`endif
      end
    end
    e.period = m_period;
    e.code   = m_code;
    e.valid  = m_valid;
    return e;
  endfunction

  // One cycle without a new rising edge: outputs must hold unless a timeout is due.
  task automatic step();
    int to_exp;
    @(negedge Clock);
    cyc++;
    to_exp = 0;
    if (m_state != 0 && cyc == TO + 1) begin
      to_exp = 1; m_state = 0; m_code = 0; m_valid = 0; m_cand = 0;
    end
    check_val("timeout", timeout, to_exp);
    check_val("bad_hold", bad_interval, 0);
    check_val("code_hold", speed_code, m_code);
    check_val("valid_hold", valid, m_valid);
    check_val("period_hold", period, m_period);
    if (to_exp == 1)
      $display("timeout cyc=%0d code=%0d valid=%0d period=%0d", cyc, speed_code, valid, period);
  endtask

  // Rising edge, held high for hi cycles, then low for lo cycles (lo<0 leaves tick high).
  task automatic pulse(input int hi, input int lo);
    exp_t e;
    int   gap;
    gap  = cyc + 1;
    tick = 1'b1;
    sb.push_back(model_edge(gap));
    @(negedge Clock);
    cyc = 0;
    e = sb.pop_front();
    check_val("period", period, e.period);
    check_val("speed_code", speed_code, e.code);
    check_val("valid", valid, e.valid);
    check_val("bad_interval", bad_interval, e.bad);
    check_val("timeout_at_edge", timeout, 0);
    $display("edge gap=%0d period=%0d code=%0d valid=%0d bad=%0d", gap, period, speed_code,
             valid, bad_interval);
    repeat (hi - 1) step();
    if (lo >= 0) begin
      tick = 1'b0;
      repeat (lo) step();
    end
  endtask

  initial begin
    Resetn = 1'b0;
    tick   = 1'b0;
    model_reset();
    repeat (3) @(negedge Clock);
    Resetn = 1'b1;
    repeat (2) step();

    // Three ticks 20 apart, stay locked, then a 30 interval and relock.
    repeat (4) pulse(1, 19);
    pulse(1, 29);
    pulse(1, 19);
    pulse(1, 19);
    pulse(1, 39);

    // Lock at 40, then let it time out; next edge only re-arms.
    pulse(1, 39);
    pulse(1, 39);
    pulse(1, 80);
    pulse(1, 37);

    // Window edges: 38, 42 half; 37, 43 bad; 8 eighth.
    pulse(1, 41);
    pulse(1, 36);
    pulse(1, 42);
    pulse(1, 7);
    pulse(1, 7);
    pulse(1, 64);

    // Edge coincident with count==TIMEOUT_CYC (P=65), then P=2.
    pulse(1, 1);
    pulse(1, 1);

    // Tick high 5 cycles every 10.
    repeat (5) pulse(5, 5);

    // Reset mid-interval with tick high, released with tick still high.
    pulse(3, -1);
    Resetn = 1'b0;
    model_reset();
    step();
    Resetn = 1'b1;
    repeat (4) step();
    tick = 1'b0;
    repeat (2) step();
    repeat (3) pulse(1, 19);

    check_val("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/speed_tick_decoder.md
# speed_tick_decoder

Receive-side counterpart of the car-game speed tick generator. It watches a single speed-tick pulse stream and measures the interval between rising edges in Clock cycles. It classifies the interval as eighth, quarter or half second and reports a locked speed code to the game logic. Loss of ticks produces a timeout, and off-nominal intervals produce a bad-interval flag.

## Interface
Parameters:
- W, 27: width of the interval counter and the period output.
- EIGHTH_CYC, 6250001: nominal eighth-second interval in cycles.
- QUARTER_CYC, 12500001: nominal quarter-second interval.
- HALF_CYC, 25000001: nominal half-second interval.
- TOL, 1024: accepted deviation in cycles, ± around each nominal value.
- TIMEOUT_CYC, 33554431: count value at which a missing tick is declared. Must be greater than HALF_CYC+TOL and no greater than 2^W-1.

Ports:
- Clock  in  1  system clock (50 MHz).
- Resetn  in  1  synchronous, active-low reset.
- tick  in  1  speed tick. Any level pattern is accepted; only rising edges count.
- speed_code  out  2  0 none, 1 eighth, 2 quarter, 3 half.
- valid  out  1  speed_code is locked.
- period  out  W  last measured interval in cycles.
- timeout  out  1  one-cycle pulse when TIMEOUT_CYC is reached without a tick.
- bad_interval  out  1  one-cycle pulse when a measured interval falls outside every window.

## Operation
- Edge detection: edge = tick & ~tick_q, where tick_q is tick registered.
- States:
  - IDLE: no reference edge yet. Counter held at 0.
  - ARMED: counting from the last edge, not locked.
  - LOCKED: counting, valid=1.
- IDLE + edge → ARMED, count←0.
- ARMED/LOCKED each cycle without an edge:
  - count←count+1, saturating at TIMEOUT_CYC.
  - When count==TIMEOUT_CYC and there is no edge: → IDLE, valid←0, speed_code←0, timeout=1. period holds its value.
- ARMED/LOCKED + edge:
  - P = count+1, saturated to W bits. period←P, count←0.
  - P is classified against each window [N−TOL, N+TOL]. Windows must not overlap. The check order is eighth, quarter, half.
- On a matched class C:
  - LOCK2 disabled: → LOCKED, speed_code←C, valid←1.
  - LOCK2 enabled: lock only if C equals the candidate class from the previous interval. Otherwise stay in or go to ARMED with candidate←C, valid←0, speed_code←0.
  - LOCKED with a new matching class C′≠C: behaves as a fresh candidate under LOCK2. Without LOCK2, speed_code switches to C′ immediately.
- On no match: bad_interval=1, → ARMED, valid←0, speed_code←0, candidate cleared.
- Simultaneous edge and count==TIMEOUT_CYC: the edge wins. P=TIMEOUT_CYC+1 (saturated) → no match → bad_interval, no timeout pulse.

## Timing
- Reset values: speed_code=0, valid=0, period=0, timeout=0, bad_interval=0, state=IDLE, count=0, candidate=none.
- tick_q resets to 1, so a tick already high at reset release is not an edge.
- Latency: all outputs update on the Clock edge at which the tick rise is first sampled (edge computed from tick and tick_q). They are visible in the following cycle.
- timeout and bad_interval are high for exactly one cycle and are never asserted together.
- Reset asserted mid-measurement clears everything within that cycle. Any partial interval is discarded.
- Ticks spaced one cycle apart (tick toggling 1,0,1) are valid edges and give P=2.

## Configuration
- SPEED_TICK_DECODER_LOCK2_EN:
  - Defined: two consecutive intervals of the same class are required before valid rises, or before speed_code changes while locked.
  - Undefined: a single matched interval locks. The candidate register is omitted.

## Structure
- Shared package speed_pkg:
  - speed code constants SPD_NONE/SPD_EIGHTH/SPD_QUARTER/SPD_HALF.
  - default cycle constants (EIGHTH/QUARTER/HALF at 50 MHz).
  - state encoding ST_IDLE/ST_ARMED/ST_LOCKED.
- Sub-module speed_window_classify: combinational compare of P against the three windows. Outputs a 2-bit class plus a match flag.
- Top level holds the edge detector, counter, FSM and output registers.

## Test plan
Simulation parameters: W=8, EIGHTH_CYC=10, QUARTER_CYC=20, HALF_CYC=40, TOL=2, TIMEOUT_CYC=64.
- Release reset, then three 1-cycle ticks spaced 20 cycles apart:
  - LOCK2 off: valid=1, speed_code=2, period=20 after the 2nd tick.
  - LOCK2 on: the same values after the 3rd tick.
- Locked at 20, then an interval of 30 → bad_interval pulses once, valid=0, speed_code=0, period=30. Two further 20-cycle intervals relock to code 2.
- Locked at 40, then no tick → timeout pulses exactly once 64 cycles after the last edge; speed_code=0, valid=0, period stays 40. The next tick returns to ARMED with no output change.
- Window edges: intervals of 38 and 42 classify as half; 37 and 43 assert bad_interval. An interval of 8 classifies as eighth.
- tick held high for 5 cycles, then low, repeated every 10 cycles → one edge per high period; locks to speed_code=1 with period=10.
- Resetn low for 1 cycle mid-interval while tick is high, then released with tick still high → no edge. All outputs 0 and state IDLE until the next rising edge.
